// File: rtl/conv_seq_ctrl.sv
// Tap sequencer for the PE input mux and MAC accumulator (3x3 filter over 4x4 input).
// Define CONV_PAD_EN for zero-padding (pad 1) mode with a 4x4 output; default is valid mode.
module conv_seq_ctrl #(
    parameter int MAC_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       last_tap,
    output logic       out_valid,
    output logic [1:0] out_row,
    output logic [1:0] out_col,
    output logic       busy,
    output logic       done
);

`ifdef CONV_PAD_EN
    localparam logic [1:0] OMAX = 2'd3;
`else
    localparam logic [1:0] OMAX = 2'd1;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t     state, next_state;
    logic [1:0] oi, oj, ki, kj;
    logic [1:0] oi_n, oj_n, ki_n, kj_n;
    logic [2:0] drain_cnt, drain_n;
    logic [3:0] s0_n, s1_n;
    logic       clr_n, en_n, last_n, busy_n, done_n;
    logic       issue, final_tap;
    logic [7:0] sel;
    logic [4:0] pipe [MAC_LAT];

    // counters always describe the tap currently presented on s0/s1
    assign final_tap = (oi == OMAX) && (oj == OMAX) &&
                       (ki == 2'd2) && (kj == 2'd2);

    assign out_valid = pipe[MAC_LAT-1][4];
    assign out_row   = pipe[MAC_LAT-1][3:2];
    assign out_col   = pipe[MAC_LAT-1][1:0];

    function automatic logic [7:0] tap_sel(input logic [1:0] p_i, p_j,
                                           input logic [1:0] f_i, f_j);
`ifdef CONV_PAD_EN
        logic [2:0] r, c;
        logic [1:0] rc, cc;
        logic       oob;
        r   = {1'b0, p_i} + {1'b0, f_i};
        c   = {1'b0, p_j} + {1'b0, f_j};
        oob = (r == 3'd0) || (r > 3'd4) || (c == 3'd0) || (c > 3'd4);
        rc  = (r == 3'd0) ? 2'd0 : (r > 3'd4) ? 2'd3 : 2'(r - 3'd1);
        cc  = (c == 3'd0) ? 2'd0 : (c > 3'd4) ? 2'd3 : 2'(c - 3'd1);
        return {(oob ? 4'hF : {f_j, f_i}), cc, rc};
`else
        logic [1:0] rs, cs;
        rs = p_i + f_i;
        cs = p_j + f_j;
        return {f_j, f_i, cs, rs};
`endif
    endfunction

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (final_tap) next_state = DRAIN;
            DRAIN:   if (drain_cnt == 3'(MAC_LAT - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // next values of counters and registered outputs
    always_comb begin
        oi_n    = oi;
        oj_n    = oj;
        ki_n    = ki;
        kj_n    = kj;
        drain_n = drain_cnt;
        s0_n    = s0;
        s1_n    = s1;
        clr_n   = 1'b0;
        en_n    = 1'b0;
        last_n  = 1'b0;
        issue   = 1'b0;
        sel     = 8'h0;
        case (state)
            IDLE: begin
                if (start) begin
                    oi_n  = 2'd0;
                    oj_n  = 2'd0;
                    ki_n  = 2'd0;
                    kj_n  = 2'd0;
                    issue = 1'b1;
                end
            end
            RUN: begin
                if (final_tap) begin
                    s1_n    = 4'hF;
                    drain_n = 3'd0;
                end else if (!stall) begin
                    issue = 1'b1;
                    if (kj != 2'd2) kj_n = kj + 2'd1;
                    else begin
                        kj_n = 2'd0;
                        if (ki != 2'd2) ki_n = ki + 2'd1;
                        else begin
                            ki_n = 2'd0;
                            if (oj != OMAX) oj_n = oj + 2'd1;
                            else begin
                                oj_n = 2'd0;
                                oi_n = oi + 2'd1;
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                s1_n    = 4'hF;
                drain_n = drain_cnt + 3'd1;
            end
            default: s1_n = 4'hF;
        endcase
        if (issue) begin
            sel    = tap_sel(oi_n, oj_n, ki_n, kj_n);
            s0_n   = sel[3:0];
            s1_n   = sel[7:4];
            en_n   = 1'b1;
            clr_n  = (ki_n == 2'd0) && (kj_n == 2'd0);
            last_n = (ki_n == 2'd2) && (kj_n == 2'd2);
        end
        busy_n = (next_state == RUN) || (next_state == DRAIN);
        done_n = (next_state == DONE);
    end

    // counter and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oi        <= 2'd0;
            oj        <= 2'd0;
            ki        <= 2'd0;
            kj        <= 2'd0;
            drain_cnt <= 3'd0;
            s0        <= 4'h0;
            s1        <= 4'hF;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            last_tap  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            oi        <= oi_n;
            oj        <= oj_n;
            ki        <= ki_n;
            kj        <= kj_n;
            drain_cnt <= drain_n;
            s0        <= s0_n;
            s1        <= s1_n;
            acc_clr   <= clr_n;
            acc_en    <= en_n;
            last_tap  <= last_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // completion pipeline matching the MAC latency; never stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAC_LAT; i++) pipe[i] <= 5'd0;
        end else begin
            pipe[0] <= {last_tap, oi, oj};
            for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed self-checking bench for conv_seq_ctrl.
// Follows CONV_PAD_EN so either build can be exercised.
module tb_conv_seq_ctrl;

    localparam int ML = 2;
`ifdef CONV_PAD_EN
    localparam int NW    = 4;
    localparam int NTAPS = 144;
`else
    localparam int NW    = 2;
    localparam int NTAPS = 36;
`endif
    localparam int NPOS   = NW * NW;
    localparam int DONE_C = NTAPS + 1 + ML;
    localparam logic [17:0] RST_V = {4'h0, 4'hF, 10'h000};

    logic       clk, reset, start, stall;
    logic [3:0] s0, s1;
    logic       acc_clr, acc_en, last_tap, out_valid, busy, done;
    logic [1:0] out_row, out_col;

    conv_seq_ctrl #(.MAC_LAT(ML)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .s0(s0), .s1(s1), .acc_clr(acc_clr), .acc_en(acc_en),
        .last_tap(last_tap), .out_valid(out_valid),
        .out_row(out_row), .out_col(out_col),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {s0, s1, acc_clr, acc_en, last_tap, out_valid,
                  out_row, out_col, busy, done};

    int          cyc, ncheck, npass, nfail;
    int          n_en, n_done, done_at;
    logic [17:0] lg [0:199];
    int          clr_q [$];
    int          ov_c  [$];
    int          ov_rc [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ncheck++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < 200) lg[cyc] = obs;
        if (acc_en) n_en++;
        if (acc_clr) clr_q.push_back(cyc);
        if (out_valid) begin
            ov_c.push_back(cyc);
            ov_rc.push_back(int'({out_row, out_col}));
        end
        if (done) begin
            n_done++;
            done_at = cyc;
        end
    endtask

    task automatic run(input int st_at, input int st_n, input int rs_at,
                       input int rst_at, input int max_c);
        cyc     = 0;
        n_en    = 0;
        n_done  = 0;
        done_at = -1;
        clr_q.delete();
        ov_c.delete();
        ov_rc.delete();
        for (int i = 0; i < 200; i++) lg[i] = 18'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < max_c) begin
            stall = (cyc >= st_at) && (cyc < st_at + st_n);
            start = (cyc == rs_at);
            if (cyc == rst_at) reset = 1'b1;
            else if (cyc == rst_at + 1) reset = 1'b0;
            tick();
        end
        stall = 1'b0;
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        ncheck = 0;
        npass  = 0;
        nfail  = 0;
        cyc    = 0;
        reset  = 1'b1;
        start  = 1'b0;
        stall  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(obs), 32'(RST_V));
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_state", 32'(obs), 32'(RST_V));

        // basic run
        run(-1, 0, -1, -1, DONE_C + 4);
        chk("basic_n_en", n_en, NTAPS);
        chk("basic_n_clr", clr_q.size(), NPOS);
        for (int i = 0; i < NPOS; i++)
            chk("basic_clr_cyc", (i < clr_q.size()) ? clr_q[i] : -1, 1 + 9 * i);
        chk("basic_n_ov", ov_c.size(), NPOS);
        for (int i = 0; i < NPOS; i++) begin
            chk("basic_ov_cyc", (i < ov_c.size()) ? ov_c[i] : -1, 9 * (i + 1) + ML);
            chk("basic_ov_rc", (i < ov_rc.size()) ? ov_rc[i] : -1, (i / NW) * 4 + (i % NW));
        end
        chk("basic_n_done", n_done, 1);
        chk("basic_done_cyc", done_at, DONE_C);
        chk("busy_first", lg[1][1], 1);
        chk("busy_drain", lg[DONE_C-1][1], 1);
        chk("busy_at_done", lg[DONE_C][1], 0);
        chk("last_tap_c9", lg[9][7], 1);
        chk("last_tap_c8", lg[8][7], 0);
        chk("drain_s1", lg[NTAPS+1][13:10], 4'hF);
        chk("drain_en", lg[NTAPS+1][8], 0);
`ifdef CONV_PAD_EN
        chk("pad00_s1", lg[1][13:10], 4'hF);
        chk("pad00_clr", lg[1][9], 1);
        chk("pad33_s0", lg[140][17:14], 4'hF);
        chk("pad33_s1", lg[140][13:10], 4'h5);
`else
        chk("sel10_s0", lg[26][17:14], 4'h7);
        chk("sel10_s1", lg[26][13:10], 4'h6);
        chk("sel01_s0", lg[12][17:14], 4'hC);
        chk("sel01_s1", lg[12][13:10], 4'h8);
`endif

        // stall sampled on edges 4..6
        run(4, 3, -1, -1, DONE_C + 6);
        chk("stall_n_en", n_en, NTAPS);
        chk("stall_en_c4", lg[4][8], 1);
        for (int c = 5; c <= 7; c++) begin
            chk("stall_en_off", lg[c][8], 0);
            chk("stall_s0_hold", lg[c][17:14], lg[4][17:14]);
            chk("stall_s1_hold", lg[c][13:10], lg[4][13:10]);
        end
        chk("stall_en_c8", lg[8][8], 1);
        chk("stall_n_ov", ov_c.size(), NPOS);
        for (int i = 0; i < NPOS; i++)
            chk("stall_ov_cyc", (i < ov_c.size()) ? ov_c[i] : -1, 9 * (i + 1) + ML + 3);
        chk("stall_done_cyc", done_at, DONE_C + 3);

        // start while busy is ignored
        run(-1, 0, 5, -1, DONE_C + 6);
        chk("restart_n_ov", ov_c.size(), NPOS);
        chk("restart_n_done", n_done, 1);
        chk("restart_done_cyc", done_at, DONE_C);

        // reset in the middle of a run
        run(-1, 0, -1, 12, 60);
        chk("midrst_outputs", 32'(lg[13]), 32'(RST_V));
        chk("midrst_n_ov", ov_c.size(), 1);
        chk("midrst_n_done", n_done, 0);

        // clean run after reset
        run(-1, 0, -1, -1, DONE_C + 4);
        chk("after_n_en", n_en, NTAPS);
        chk("after_n_ov", ov_c.size(), NPOS);
        chk("after_done_cyc", done_at, DONE_C);

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Sequencer for the PE input mux path (4x4 input matrix a, 3x3 filter b).
- Generates the s0/s1 mux selects that walk every filter tap for every output position of a 2D convolution (stride 1, valid mode).
- Drives the downstream MAC accumulator controls and flags each finished output element with its row/column.
- Sits between the top-level start/done control and the PE input mux + MAC.

Parameters:
- MAC_LAT, 2: cycles from a tap's selects being presented to that tap's product being in the accumulator; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a convolution when idle.
- stall  input  1  freezes tap issue while high.
- s0  output  4  a-mux select: s0[1:0] = a row index, s0[3:2] = a column index.
- s1  output  4  b-mux select: s1[1:0] = filter row ki, s1[3:2] = filter column kj; 2'b11 in either field gives b_out=0.
- acc_clr  output  1  accumulator loads the product instead of adding it (first tap of each position).
- acc_en  output  1  the current selects form a valid tap.
- last_tap  output  1  the current tap is tap 8 of a position.
- out_valid  output  1  accumulator holds a finished output element.
- out_row  output  2  output row of the element flagged by out_valid.
- out_col  output  2  output column of the element flagged by out_valid.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the run completes.

Behaviour:
- Clock and reset: one clock, clk. Asynchronous active-high reset, named reset.
- Reset values: state=IDLE; s0=4'h0; s1=4'hF (b_out=0); acc_clr, acc_en, last_tap, out_valid, busy, done all 0; out_row=0, out_col=0; all counters and the delay pipeline cleared.
- All outputs are registered.
- FSM states:
  - IDLE: start=1 -> RUN.
  - RUN: on the last tap of the last position -> DRAIN.
  - DRAIN: after MAC_LAT cycles -> DONE.
  - DONE: 1 cycle -> IDLE.
- start is ignored in every state except IDLE.
- Issue order: counters oi, oj, ki, kj, with kj innermost and oi outermost. kj, ki range 0..2; oi, oj range 0..1.
- Tap selects:
  - a row = oi+ki, a column = oj+kj.
  - s0 = {oj+kj, oi+ki}; s1 = {kj, ki}.
- First tap appears the cycle after start is sampled, then one tap per non-stalled cycle. Total 36 taps.
- acc_en=1 on every issued tap. acc_clr=1 together with acc_en when ki=kj=0. last_tap=1 when ki=kj=2.
- stall=1 in RUN:
  - s0/s1 hold their values; acc_en, acc_clr and last_tap are forced 0; counters do not advance.
  - Issue resumes on the same tap when stall drops.
- stall has no effect in IDLE, DRAIN or DONE.
- Completion pipeline:
  - A MAC_LAT-deep shift register carries {last_tap, oi, oj}.
  - out_valid/out_row/out_col fire exactly MAC_LAT cycles after each issued last_tap.
  - The pipeline is never stalled.
- DRAIN: s1=4'hF and acc_en=0; lasts MAC_LAT cycles, so the final out_valid occurs in the last DRAIN cycle.
- done pulses in DONE, i.e. the cycle after the final out_valid. busy drops in the same cycle.
- No-stall timing (start sampled at cycle 0): taps in cycles 1..36; out_valid at cycles 9+MAC_LAT, 18+MAC_LAT, 27+MAC_LAT, 36+MAC_LAT; done at cycle 37+MAC_LAT.
- Reset mid-run: immediate return to reset values. Pending pipeline entries are discarded, so no out_valid follows.
- start and stall both high in IDLE: the run starts; stall takes effect from the first RUN cycle.

Optional Feature:
- Macro: CONV_PAD_EN.
- Defined: zero-padding (pad 1) mode, giving a 4x4 output.
  - Output position counters oi, oj range 0..3; 144 taps total.
  - Source coordinates: r = oi+ki-1, c = oj+kj-1.
  - If r or c falls outside 0..3: s1 = 4'hF (forces b_out=0); s0 = {c clamped to 0..3, r clamped to 0..3}; acc_en/acc_clr/last_tap unchanged.
  - Otherwise s0 = {c, r} and s1 = {kj, ki}.
  - out_row/out_col span 0..3.
  - Final out_valid at cycle 144+MAC_LAT; done at cycle 145+MAC_LAT.
- Undefined: valid mode exactly as in Behaviour; no padding logic is synthesized.

Test Plan:
- Basic run (MAC_LAT=2): reset, start at cycle 0, no stall -> 36 acc_en cycles; acc_clr at cycles 1, 10, 19, 28; out_valid at cycles 11, 20, 29, 38 with (row,col) = (0,0), (0,1), (1,0), (1,1); done at 39.
- Select check: position (1,0), tap ki=2, kj=1 -> s0=4'h7, s1=4'h6. Position (0,1), tap ki=0, kj=2 -> s0=4'hC, s1=4'h8.
- Stall: stall high for 3 cycles during tap 4 of position 0 -> s0/s1 frozen and acc_en=0 for those 3 cycles; all later events (out_valid, done) shift by +3.
- Start while busy: second start pulse at cycle 5 -> ignored; exactly 4 out_valid pulses and 1 done.
- Reset mid-run: reset asserted at cycle 12 -> next cycle all outputs at reset values; no further out_valid; a new start then runs cleanly to completion.
- With CONV_PAD_EN: position (0,0), tap ki=0, kj=0 -> s1=4'hF, acc_clr=1. Position (3,3), tap ki=1, kj=1 -> s0=4'hF, s1=4'h5. Run produces 16 out_valid pulses; done at cycle 147.
